// File: rtl/pulse_gen.sv
// Square-wave pulse channel: duty sequencer, sweep unit, envelope and
// length counter, producing a signed registered sample.
module pulse_gen #(
  parameter int NEG_ONES = 0,
  parameter int OUT_W    = 5
) (
  input  logic                    apu_clk,
  input  logic                    reset,
  input  logic                    qtr_tick,
  input  logic                    hlf_tick,
  input  logic                    wr_en,
  input  logic [1:0]              wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    ch_enable,
  output logic signed [OUT_W-1:0] pulse_out,
  output logic                    active
);

  localparam int PADW = OUT_W - 4;
  localparam logic [12:0] LP_ONES =
    (NEG_ONES != 0) ? 13'd1 : 13'd0;

  logic [7:0]  r_reg0;
  logic [7:0]  r_reg1;
  logic [10:0] r_period;
  logic [10:0] r_timer;
  logic [2:0]  r_seq;
  logic [7:0]  r_len;
  logic [3:0]  r_env_cnt;
  logic [3:0]  r_env_div;
  logic [2:0]  r_sw_div;
  logic        r_start;
  logic        r_reload;

  logic        w_wr0, w_wr1, w_wr2, w_wr3;
  logic [1:0]  w_duty;
  logic        w_halt;
  logic        w_cvol;
  logic [3:0]  w_vper;
  logic        w_sw_en;
  logic [2:0]  w_sw_per;
  logic        w_sw_neg;
  logic [2:0]  w_sw_sh;
  logic [10:0] w_delta;
  logic [11:0] w_sum;
  logic [12:0] w_diff;
  logic [11:0] w_target;
  logic        w_mute;
  logic        w_sweep;
  logic [7:0]  w_len_tab;
  logic [7:0]  w_pat;
  logic [3:0]  w_vol;
  logic signed [OUT_W-1:0] w_mag;
  logic signed [OUT_W-1:0] w_sample;

  assign w_wr0 = wr_en && (wr_addr == 2'd0);
  assign w_wr1 = wr_en && (wr_addr == 2'd1);
  assign w_wr2 = wr_en && (wr_addr == 2'd2);
  assign w_wr3 = wr_en && (wr_addr == 2'd3);

  assign w_duty   = r_reg0[7:6];
  assign w_halt   = r_reg0[5];
  assign w_cvol   = r_reg0[4];
  assign w_vper   = r_reg0[3:0];
  assign w_sw_en  = r_reg1[7];
  assign w_sw_per = r_reg1[6:4];
  assign w_sw_neg = r_reg1[3];
  assign w_sw_sh  = r_reg1[2:0];

  // Negative sweep can only go below zero via the one's-complement -1.
  assign w_delta = r_period >> w_sw_sh;
  assign w_sum   = {1'b0, r_period} + {1'b0, w_delta};
  assign w_diff  = {2'b00, r_period} - {2'b00, w_delta} - LP_ONES;
  assign w_target = w_sw_neg
                  ? (w_diff[12] ? 12'd0 : w_diff[11:0])
                  : w_sum;

  assign w_mute = (r_len == 8'd0)
               || (r_period < 11'd8)
               || (!w_sw_neg && (w_target > 12'h7FF));

  assign w_sweep = hlf_tick && (r_sw_div == 3'd0) && w_sw_en
                && (w_sw_sh != 3'd0) && !w_mute;

  // Length-counter load value selected by the written len_idx.
  always_comb begin
    w_len_tab = 8'd0;
    unique case (wr_data[7:3])
      5'd0:  w_len_tab = 8'd10;
      5'd1:  w_len_tab = 8'd254;
      5'd2:  w_len_tab = 8'd20;
      5'd3:  w_len_tab = 8'd2;
      5'd4:  w_len_tab = 8'd40;
      5'd5:  w_len_tab = 8'd4;
      5'd6:  w_len_tab = 8'd80;
      5'd7:  w_len_tab = 8'd6;
      5'd8:  w_len_tab = 8'd160;
      5'd9:  w_len_tab = 8'd8;
      5'd10: w_len_tab = 8'd60;
      5'd11: w_len_tab = 8'd10;
      5'd12: w_len_tab = 8'd14;
      5'd13: w_len_tab = 8'd12;
      5'd14: w_len_tab = 8'd26;
      5'd15: w_len_tab = 8'd14;
      5'd16: w_len_tab = 8'd12;
      5'd17: w_len_tab = 8'd16;
      5'd18: w_len_tab = 8'd24;
      5'd19: w_len_tab = 8'd18;
      5'd20: w_len_tab = 8'd48;
      5'd21: w_len_tab = 8'd20;
      5'd22: w_len_tab = 8'd96;
      5'd23: w_len_tab = 8'd22;
      5'd24: w_len_tab = 8'd192;
      5'd25: w_len_tab = 8'd24;
      5'd26: w_len_tab = 8'd72;
      5'd27: w_len_tab = 8'd26;
      5'd28: w_len_tab = 8'd16;
      5'd29: w_len_tab = 8'd28;
      5'd30: w_len_tab = 8'd32;
      5'd31: w_len_tab = 8'd30;
      default: w_len_tab = 8'd0;
    endcase
  end

  // Duty waveform, bit n is the level at sequencer step n.
  always_comb begin
    w_pat = 8'h00;
    unique case (w_duty)
      2'd0: w_pat = 8'b00000010;
      2'd1: w_pat = 8'b00000110;
      2'd2: w_pat = 8'b00011110;
      2'd3: w_pat = 8'b11111001;
      default: w_pat = 8'h00;
    endcase
  end

  assign w_vol    = w_cvol ? w_vper : r_env_cnt;
  assign w_mag    = {{PADW{1'b0}}, w_vol};
  assign w_sample = w_mute ? '0
                  : (w_pat[r_seq] ? w_mag : -w_mag);

  assign active = (r_len != 8'd0);

  // Control registers r0 and r1.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_reg0 <= 8'd0;
      r_reg1 <= 8'd0;
    end else begin
      if (w_wr0) r_reg0 <= wr_data;
      if (w_wr1) r_reg1 <= wr_data;
    end
  end

  // Period: CPU writes win over a sweep update in the same cycle.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_period <= 11'd0;
    end else if (w_wr2 || w_wr3) begin
      if (w_wr2) r_period[7:0]  <= wr_data;
      if (w_wr3) r_period[10:8] <= wr_data[2:0];
    end else if (w_sweep) begin
      r_period <= w_target[10:0];
    end
  end

  // Sweep divider; an r1 write re-arms the reload flag.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_sw_div <= 3'd0;
      r_reload <= 1'b0;
    end else begin
      if (hlf_tick) begin
        if ((r_sw_div == 3'd0) || r_reload) begin
          r_sw_div <= w_sw_per;
          r_reload <= 1'b0;
        end else begin
          r_sw_div <= r_sw_div - 3'd1;
        end
      end
      if (w_wr1) r_reload <= 1'b1;
    end
  end

  // Period timer steps the sequencer downward; r3 restarts it.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_timer <= 11'd0;
      r_seq   <= 3'd0;
    end else begin
      if (r_timer == 11'd0) begin
        r_timer <= r_period;
        r_seq   <= r_seq - 3'd1;
      end else begin
        r_timer <= r_timer - 11'd1;
      end
      if (w_wr3) r_seq <= 3'd0;
    end
  end

  // Length counter: disable clears, r3 load beats the decrement.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_len <= 8'd0;
    end else if (!ch_enable) begin
      r_len <= 8'd0;
    end else if (w_wr3) begin
      r_len <= w_len_tab;
    end else if (hlf_tick && !w_halt && (r_len != 8'd0)) begin
      r_len <= r_len - 8'd1;
    end
  end

  // Envelope; an r3 write keeps the start flag for the next tick.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) begin
      r_start   <= 1'b0;
      r_env_cnt <= 4'd0;
      r_env_div <= 4'd0;
    end else begin
      if (qtr_tick) begin
        if (r_start) begin
          r_start   <= 1'b0;
          r_env_cnt <= 4'd15;
          r_env_div <= w_vper;
        end else if (r_env_div != 4'd0) begin
          r_env_div <= r_env_div - 4'd1;
        end else begin
          r_env_div <= w_vper;
          if (r_env_cnt != 4'd0)
            r_env_cnt <= r_env_cnt - 4'd1;
          else if (w_halt)
            r_env_cnt <= 4'd15;
        end
      end
      if (w_wr3) r_start <= 1'b1;
    end
  end

  // Registered output sample.
  always_ff @(posedge apu_clk or posedge reset) begin
    if (reset) pulse_out <= '0;
    else       pulse_out <= w_sample;
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: two instances share stimulus,
// one two's-complement/5-bit, one one's-complement/8-bit.
module tb_pulse_gen;

  logic              apu_clk = 1'b0;
  logic              reset;
  logic              qtr_tick;
  logic              hlf_tick;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              ch_enable;
  logic signed [4:0] po0;
  logic signed [7:0] po1;
  logic              act0;
  logic              act1;

  int n_chk = 0;
  int n_err = 0;

  always #5 apu_clk = ~apu_clk;

  pulse_gen #(.NEG_ONES(0), .OUT_W(5)) dut (
    .apu_clk  (apu_clk),
    .reset    (reset),
    .qtr_tick (qtr_tick),
    .hlf_tick (hlf_tick),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ch_enable(ch_enable),
    .pulse_out(po0),
    .active   (act0)
  );

  pulse_gen #(.NEG_ONES(1), .OUT_W(8)) dut1 (
    .apu_clk  (apu_clk),
    .reset    (reset),
    .qtr_tick (qtr_tick),
    .hlf_tick (hlf_tick),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ch_enable(ch_enable),
    .pulse_out(po1),
    .active   (act1)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge apu_clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge apu_clk);
    wr_en = 1'b0;
  endtask

  task automatic hlf();
    @(negedge apu_clk); hlf_tick = 1'b1;
    @(negedge apu_clk); hlf_tick = 1'b0;
  endtask

  task automatic qtr();
    @(negedge apu_clk); qtr_tick = 1'b1;
    @(negedge apu_clk); qtr_tick = 1'b0;
  endtask

  task automatic run_len(input logic pos, output int n);
    n = 0;
    while (((po0 > 0) == pos) && (n < 100)) begin
      @(negedge apu_clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int w;
    reset = 1'b1; qtr_tick = 1'b0; hlf_tick = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    ch_enable = 1'b0;
    repeat (3) @(negedge apu_clk);
    check("rst_po", po0, 0);
    check("rst_act", act0, 0);
    reset = 1'b0;
    ch_enable = 1'b1;

    // Tone: duty 2, const vol 15, period 8, length 254
    wr(2'd1, 8'h00);
    wr(2'd0, 8'hBF);
    wr(2'd2, 8'h08);
    wr(2'd3, 8'h08);
    check("len254", dut.r_len, 254);
    check("act_on", act0, 1);
    w = 0;
    while (!(po0 > 0) && (w < 300)) begin
      @(negedge apu_clk);
      w++;
    end
    check("wait_hi", int'(po0 > 0), 1);
    check("hi_val", po0, 15);
    check("hi_ext", po1, 15);
    run_len(1'b1, n);
    check("hi_len", n, 36);
    check("lo_val", po0, -15);
    check("lo_ext", po1, -15);
    run_len(1'b0, n);
    check("lo_len", n, 36);

    // Overflowing sweep target mutes and freezes period
    wr(2'd1, 8'h81);
    wr(2'd2, 8'hF0);
    wr(2'd3, 8'h0F);
    @(negedge apu_clk);
    check("ovf_mute", po0, 0);
    check("ovf_mute1", po1, 0);
    hlf();
    check("ovf_per", dut.r_period, 'h7F0);
    hlf();
    check("ovf_per1", dut1.r_period, 'h7F0);

    // Negative sweep, two's vs one's complement
    wr(2'd1, 8'h89);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h09);
    hlf();
    check("neg2", dut.r_period, 'h080);
    check("neg1", dut1.r_period, 'h07F);

    // Sweep divider period 1: update, hold, update
    wr(2'd1, 8'h99);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h09);
    hlf();
    check("div_t1", dut.r_period, 'h080);
    hlf();
    check("div_t2", dut.r_period, 'h080);
    check("div_t2b", dut1.r_period, 'h07F);
    hlf();
    check("div_t3", dut.r_period, 'h040);
    check("div_t3b", dut1.r_period, 'h03F);

    // Envelope decay from 15 to 0, hold, then loop
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h08);
    qtr();
    @(negedge apu_clk);
    check("env15", iabs(po0), 15);
    for (int i = 14; i >= 0; i--) begin
      qtr();
      @(negedge apu_clk);
      check($sformatf("env%0d", i), iabs(po0), i);
    end
    qtr();
    @(negedge apu_clk);
    check("env_hold", iabs(po0), 0);
    wr(2'd0, 8'h20);
    qtr();
    @(negedge apu_clk);
    check("env_loop", iabs(po0), 15);

    // Length expiry and r3/hlf_tick priority
    wr(2'd0, 8'h9F);
    wr(2'd3, 8'h18);
    check("len2_act", act0, 1);
    hlf();
    check("len1_act", act0, 1);
    hlf();
    check("len0_act", act0, 0);
    @(negedge apu_clk);
    check("len0_po", po0, 0);
    @(negedge apu_clk);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h08;
    hlf_tick = 1'b1;
    @(negedge apu_clk);
    wr_en = 1'b0; hlf_tick = 1'b0;
    check("wr_prio", dut.r_len, 254);
    check("wr_prio1", dut1.r_len, 254);

    // Channel disable clears and blocks length loads
    ch_enable = 1'b0;
    @(negedge apu_clk);
    check("dis_act", act0, 0);
    wr(2'd3, 8'h08);
    check("dis_load", dut.r_len, 0);
    ch_enable = 1'b1;
    wr(2'd3, 8'h08);
    check("en_act", act0, 1);
    repeat (2) @(negedge apu_clk);
    check("tone_on", iabs(po0), 15);

    // Asynchronous reset mid-tone
    #1 reset = 1'b1;
    #1;
    check("arst_po", po0, 0);
    check("arst_po1", po1, 0);
    check("arst_act", act0, 0);
    @(negedge apu_clk);
    check("arst_hold", po0, 0);
    check("arst_per", dut.r_period, 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL provide parameter NEG_ONES, default 0, meaning sweep negate uses two's complement (0) or one's complement (1, channel-1 behaviour).
REQ-002 SHALL provide parameter OUT_W, default 5, meaning signed output width; legal range 5..16.
REQ-003 apu_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 qtr_tick  input  1  quarter-frame enable, one apu_clk cycle wide.
REQ-006 hlf_tick  input  1  half-frame enable, one apu_clk cycle wide.
REQ-007 wr_en  input  1  register write strobe.
REQ-008 wr_addr  input  2  register select 0..3.
REQ-009 wr_data  input  8  write data.
REQ-010 ch_enable  input  1  channel enable; 0 forces the length counter to 0.
REQ-011 pulse_out  output  OUT_W  signed sample, registered.
REQ-012 active  output  1  high when the length counter is non-zero.

Function
REQ-013 Register fields:
- r0: duty[7:6], halt/loop[5], const_vol[4], vol_period[3:0]
- r1: sw_en[7], sw_period[6:4], sw_neg[3], sw_shift[2:0]
- r2: period[7:0]
- r3: len_idx[7:3], period[10:8]
REQ-014 Writes to r0–r3 SHALL take effect on the next cycle.
REQ-015 A write to r2 or r3 SHALL update the 11-bit period register directly.
REQ-016 A write to r3 SHALL:
- load the length counter from the table, only if ch_enable=1;
- set the envelope start flag;
- reset the sequencer index to 0.
REQ-017 Length table, len_idx 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-018 Duty patterns, indexed by sequencer step 0..7 (LSB = step 0):
- duty 0: 8'b00000010
- duty 1: 8'b00000110
- duty 2: 8'b00011110
- duty 3: 8'b11111001
REQ-019 Timer: each apu_clk, if timer==0 then reload from period and decrement the sequencer index modulo 8 (0 wraps to 7); otherwise timer decrements.
REQ-020 Sweep target SHALL be:
- period + (period>>sw_shift) when sw_neg=0;
- period - (period>>sw_shift) when sw_neg=1, with a further -1 when NEG_ONES=1.
- Computed in 12 bits, clamped at 0 on underflow.
REQ-021 Mute SHALL be asserted when any of: length==0, period<8, or (sw_neg=0 and target>0x7FF).
REQ-022 On hlf_tick, the sweep divider SHALL behave as follows:
- If the divider==0, sw_en=1, sw_shift!=0 and not muted, then period SHALL take the target.
- If the divider==0 or the sweep reload flag is set, the divider SHALL load sw_period and the reload flag SHALL clear.
- Otherwise the divider SHALL decrement.
REQ-023 Any write to r1 SHALL set the sweep reload flag.
REQ-024 On hlf_tick, the length counter SHALL decrement when halt=0 and length!=0.
REQ-025 A simultaneous r3 write SHALL take priority over the hlf_tick length decrement.
REQ-026 On qtr_tick with the start flag set: clear the flag, set the envelope counter to 15, and set the divider to vol_period.
REQ-027 On qtr_tick without the start flag:
- divider!=0: divider decrements.
- divider==0: divider reloads vol_period, and the counter decrements if non-zero, else reloads 15 if loop=1.
REQ-028 A simultaneous r3 write and qtr_tick SHALL leave the start flag set for the next qtr_tick.
REQ-029 Volume SHALL be vol_period when const_vol=1, else the envelope counter.
REQ-030 pulse_out SHALL be 0 if muted; otherwise +volume if duty bit[index]=1, else -volume, sign-extended to OUT_W.
REQ-031 pulse_out SHALL be registered, with a latency of 1 cycle from a state change.
REQ-032 ch_enable=0 SHALL clear length within 1 cycle and block length loads while low.

Reset
REQ-033 Reset SHALL clear to 0:
- all registers, period, timer, sequencer index, length counter;
- envelope counter, envelope divider, sweep divider;
- start flag, reload flag, pulse_out, active.
REQ-034 Reset asserted mid-operation SHALL zero pulse_out immediately (asynchronously) and hold it at 0 until release.
REQ-035 The first apu_clk edge after reset release SHALL perform normal operation with no extra pipeline fill.

Verification
REQ-036 r0=0xBF, r2=0x08, r3=0x08 (len_idx 1), ch_enable=1 -> length=254, active=1; pulse_out alternates +15/-15 with duty 2 pattern; each sequencer step lasts 9 cycles.
REQ-037 period=0x7F0, sw_neg=0, shift=1 -> target 0xBE8>0x7FF -> pulse_out=0 and period unchanged on hlf_tick.
REQ-038 NEG_ONES=1 vs 0, period=0x100, shift=1, sw_neg=1, sw_en=1, sw_period=0 -> period after one hlf_tick = 0x07F vs 0x080.
REQ-039 r0=0x00 (decay, period 0), r3 write, 16 qtr_ticks -> envelope counter 15 then 14..0; holds 0 without loop; reloads 15 with loop=1.
REQ-040 Halt=0, len_idx 3 (length 2), 2 hlf_ticks -> active falls, pulse_out=0; r3 write coincident with hlf_tick -> length = new table value, not decremented.
REQ-041 Reset asserted mid-tone -> pulse_out=0 asynchronously; ch_enable=0 during tone -> active=0 next cycle; r3 write while ch_enable=0 -> length stays 0.
